apb_sram_slave: RTL and testbench

Parametrised APB slave with a word-organised register/memory array, byte strobes, programmable wait states, a read-only low region and PSLVERR generation. It is the next-generation memory slave behind the APB decoder. Versus the fixed 64-bit slave, it adds:
- generic data width and depth
- a proper IDLE/WAIT/READY access FSM
- address-range, alignment and write-protect error checking

---
 rtl/apb_sram_slave.sv | 181 ++++++++++++++++++
 tb/tb_apb_sram_slave.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/apb_sram_slave.sv
// -----------------------------------------------------------------------------
// apb_sram_slave
//   APB memory slave with a word-organised array, byte strobes, programmable
//   wait states, a read-only low region and PSLVERR generation.
//
// Ports
//   PCLK     in   1            clock, rising edge
//   PRESETn  in   1            synchronous active-low reset
//   PSEL     in   1            slave select
//   PENABLE  in   1            access phase
//   PWRITE   in   1            1 = write, 0 = read
//   PADDR    in   ADDR_WIDTH   byte address
//   PWDATA   in   DATA_WIDTH   write data
//   PSTRB    in   DATA_WIDTH/8 write byte strobes
//   PRDATA   out  DATA_WIDTH   registered read data
//   PREADY   out  1            registered transfer complete
//   PSLVERR  out  1            registered error response (valid with PREADY)
// -----------------------------------------------------------------------------
module apb_sram_slave #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 12,
   parameter int DEPTH       = 64,
   parameter int WAIT_STATES = 0,
   parameter int RO_WORDS    = 0
) (
   input  logic                    PCLK,
   input  logic                    PRESETn,
   input  logic                    PSEL,
   input  logic                    PENABLE,
   input  logic                    PWRITE,
   input  logic [ADDR_WIDTH-1:0]   PADDR,
   input  logic [DATA_WIDTH-1:0]   PWDATA,
   input  logic [DATA_WIDTH/8-1:0] PSTRB,
   output logic [DATA_WIDTH-1:0]   PRDATA,
   output logic                    PREADY,
   output logic                    PSLVERR
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int OFF_W = $clog2(BYTES);
   localparam int IDX_W = ADDR_WIDTH - OFF_W;
   localparam int MAW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(DEPTH);
   localparam logic [IDX_W:0] RO_L    = (IDX_W+1)'(RO_WORDS);
   localparam logic [3:0]     WS_L    = 4'(WAIT_STATES);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_READY = 2'd2;

   logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

   logic [1:0]            r_state;
   logic [3:0]            r_cnt;
   logic [MAW-1:0]        r_idx;
   logic                  r_wr;
   logic                  r_err;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [BYTES-1:0]      r_strb;

   logic [IDX_W-1:0]      w_idx;
   logic                  w_misalign;
   logic                  w_range_err;
   logic                  w_ro_hit;
   logic                  w_err;
   logic                  w_setup;
   logic                  w_go_ready;
   logic                  w_cur_err;
   logic                  w_cur_wr;
   logic [MAW-1:0]        w_cur_idx;

   // ---- setup-phase decode ----
   assign w_idx = PADDR[ADDR_WIDTH-1:OFF_W];

   generate
      if (OFF_W > 0) begin : g_off
         assign w_misalign = |PADDR[OFF_W-1:0];
      end else begin : g_nooff
         assign w_misalign = 1'b0;
      end
      // An empty read-only region would make the comparison constant-false.
      if (RO_WORDS > 0) begin : g_ro
         assign w_ro_hit = ({1'b0, w_idx} < RO_L);
      end else begin : g_noro
         assign w_ro_hit = 1'b0;
      end
   endgenerate

   assign w_range_err = ({1'b0, w_idx} >= DEPTH_L);
   assign w_err       = w_range_err | w_misalign | (PWRITE & w_ro_hit);

   assign w_setup = (r_state == S_IDLE) && PSEL && !PENABLE;

   // READY is entered straight from setup when there are no wait states,
   // otherwise from WAIT on the last counted edge; pick the matching
   // transfer attributes (live decode vs latched copy).
   assign w_go_ready = (w_setup && (WAIT_STATES == 0)) ||
                       ((r_state == S_WAIT) && PSEL && (r_cnt == 4'd1));
   assign w_cur_err  = (r_state == S_IDLE) ? w_err : r_err;
   assign w_cur_wr   = (r_state == S_IDLE) ? PWRITE : r_wr;
   assign w_cur_idx  = (r_state == S_IDLE) ? w_idx[MAW-1:0] : r_idx;

   // ---- setup-phase latch ----
   always_ff @(posedge PCLK) begin
      if (w_setup) begin
         r_idx   <= w_idx[MAW-1:0];
         r_wr    <= PWRITE;
         r_err   <= w_err;
         r_wdata <= PWDATA;
         r_strb  <= PSTRB;
      end
   end

   // ---- access FSM, outputs and memory ----
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         PRDATA  <= '0;
         PREADY  <= 1'b0;
         PSLVERR <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_setup) begin
                  r_cnt <= WS_L;
                  if (WAIT_STATES != 0) begin
                     r_state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (!PSEL) begin
                  r_state <= S_IDLE;
                  PREADY  <= 1'b0;
                  PSLVERR <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_READY: begin
               if (!PSEL) begin
                  r_state <= S_IDLE;
                  PREADY  <= 1'b0;
                  PSLVERR <= 1'b0;
               end else if (PENABLE && PREADY) begin
                  if (r_wr && !r_err) begin
                     for (int b = 0; b < BYTES; b++) begin
                        if (r_strb[b]) begin
                           r_mem[r_idx][b*8 +: 8] <= r_wdata[b*8 +: 8];
                        end
                     end
                  end
                  r_state <= S_IDLE;
                  PREADY  <= 1'b0;
                  PSLVERR <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               PREADY  <= 1'b0;
               PSLVERR <= 1'b0;
            end
         endcase

         if (w_go_ready) begin
            r_state <= S_READY;
            PREADY  <= 1'b1;
            PSLVERR <= w_cur_err;
            if (!w_cur_wr) begin
               PRDATA <= w_cur_err ? '0 : r_mem[w_cur_idx];
            end
         end
      end
   end

endmodule

// File: tb/tb_apb_sram_slave.sv
// -----------------------------------------------------------------------------
// tb_apb_sram_slave
//   Directed bench for apb_sram_slave: one instance with two wait states and
//   one with none, both with a four-word read-only region.
// -----------------------------------------------------------------------------
module tb_apb_sram_slave;

   logic        clk = 1'b0;
   logic        rstn;
   logic        psel0, psel1, pen, pwr;
   logic [11:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [31:0] prdata0, prdata1;
   logic        pready0, pready1, pslverr0, pslverr1;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   apb_sram_slave #(
      .DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(64), .WAIT_STATES(2), .RO_WORDS(4)
   ) u_dut_ws2 (
      .PCLK(clk), .PRESETn(rstn), .PSEL(psel0), .PENABLE(pen), .PWRITE(pwr),
      .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
      .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
   );

   apb_sram_slave #(
      .DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(64), .WAIT_STATES(0), .RO_WORDS(4)
   ) u_dut_ws0 (
      .PCLK(clk), .PRESETn(rstn), .PSEL(psel1), .PENABLE(pen), .PWRITE(pwr),
      .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
      .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One complete APB transfer; called and returning #1 after a rising edge.
   task automatic xfer(input bit d1, input bit wr, input logic [11:0] a,
                       input logic [31:0] wd, input logic [3:0] st,
                       output logic [31:0] rd, output logic err, output int acc);
      psel0 = !d1; psel1 = d1; pen = 1'b0;
      pwr = wr; paddr = a; pwdata = wd; pstrb = st;
      @(posedge clk); #1;
      pen = 1'b1;
      acc = 1;
      while ((d1 ? pready1 : pready0) !== 1'b1 && acc < 20) begin
         @(posedge clk); #1;
         acc++;
      end
      rd  = d1 ? prdata1 : prdata0;
      err = d1 ? pslverr1 : pslverr0;
      @(posedge clk); #1;
      psel0 = 1'b0; psel1 = 1'b0; pen = 1'b0;
      chk("pready_one_cycle", {63'd0, (d1 ? pready1 : pready0)}, 64'd0);
   endtask

   logic [31:0] rd;
   logic        err;
   int          acc;
   int          c0;

   initial begin
      rstn = 1'b0; psel0 = 1'b0; psel1 = 1'b0; pen = 1'b0; pwr = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_prdata0",  {32'd0, prdata0}, 64'd0);
      chk("rst_pready0",  {63'd0, pready0}, 64'd0);
      chk("rst_pslverr0", {63'd0, pslverr0}, 64'd0);
      chk("rst_prdata1",  {32'd0, prdata1}, 64'd0);
      chk("rst_pready1",  {63'd0, pready1}, 64'd0);
      rstn = 1'b1;
      @(posedge clk); #1;

      // basic write / read with two wait states
      xfer(1'b0, 1'b1, 12'h040, 32'hDEADBEEF, 4'hF, rd, err, acc);
      chk("t1_wr_acc", 64'(acc), 64'd3);
      chk("t1_wr_err", {63'd0, err}, 64'd0);
      xfer(1'b0, 1'b0, 12'h040, 32'h0, 4'h0, rd, err, acc);
      chk("t1_rd_acc",  64'(acc), 64'd3);
      chk("t1_rd_data", {32'd0, rd}, 64'hDEADBEEF);
      chk("t1_rd_err",  {63'd0, err}, 64'd0);

      // partial byte strobes
      xfer(1'b0, 1'b1, 12'h044, 32'h11223344, 4'hF, rd, err, acc);
      xfer(1'b0, 1'b1, 12'h044, 32'hAABBCCDD, 4'h5, rd, err, acc);
      chk("t2_wr_err", {63'd0, err}, 64'd0);
      xfer(1'b0, 1'b0, 12'h044, 32'h0, 4'hF, rd, err, acc);
      chk("t2_rd_data", {32'd0, rd}, 64'h11BB33DD);

      // out-of-range and misaligned reads
      xfer(1'b0, 1'b0, 12'h100, 32'h0, 4'h0, rd, err, acc);
      chk("t4_oor_err",  {63'd0, err}, 64'd1);
      chk("t4_oor_data", {32'd0, rd}, 64'd0);
      xfer(1'b0, 1'b0, 12'h040, 32'h0, 4'h0, rd, err, acc);
      chk("t4_reread", {32'd0, rd}, 64'hDEADBEEF);
      xfer(1'b0, 1'b0, 12'h042, 32'h0, 4'h0, rd, err, acc);
      chk("t4_mis_err",  {63'd0, err}, 64'd1);
      chk("t4_mis_data", {32'd0, rd}, 64'd0);

      // write to the read-only region
      xfer(1'b0, 1'b1, 12'h008, 32'h55AA55AA, 4'hF, rd, err, acc);
      chk("t3_ro_err", {63'd0, err}, 64'd1);
      chk("t3_ro_acc", 64'(acc), 64'd3);
      xfer(1'b0, 1'b0, 12'h008, 32'h0, 4'h0, rd, err, acc);
      chk("t3_rd_data", {32'd0, rd}, 64'd0);
      chk("t3_rd_err",  {63'd0, err}, 64'd0);

      // all-zero strobe write is legal and changes nothing
      xfer(1'b0, 1'b1, 12'h040, 32'h01234567, 4'h0, rd, err, acc);
      chk("zstrb_err", {63'd0, err}, 64'd0);
      xfer(1'b0, 1'b0, 12'h040, 32'h0, 4'h0, rd, err, acc);
      chk("zstrb_data", {32'd0, rd}, 64'hDEADBEEF);

      // zero wait states, back-to-back transfers
      c0 = cyc;
      xfer(1'b1, 1'b1, 12'h010, 32'h12345678, 4'hF, rd, err, acc);
      chk("t5_w1_acc", 64'(acc), 64'd1);
      xfer(1'b1, 1'b1, 12'h014, 32'hCAFEF00D, 4'hF, rd, err, acc);
      chk("t5_w2_acc", 64'(acc), 64'd1);
      xfer(1'b1, 1'b0, 12'h010, 32'h0, 4'h0, rd, err, acc);
      chk("t5_rd_acc",  64'(acc), 64'd1);
      chk("t5_rd_data", {32'd0, rd}, 64'h12345678);
      chk("t5_cycles",  64'(cyc - c0), 64'd6);
      xfer(1'b1, 1'b0, 12'h014, 32'h0, 4'h0, rd, err, acc);
      chk("t5_rd2_data", {32'd0, rd}, 64'hCAFEF00D);

      // reset during the wait phase of a write
      psel0 = 1'b1; pen = 1'b0; pwr = 1'b1; paddr = 12'h050;
      pwdata = 32'h87654321; pstrb = 4'hF;
      @(posedge clk); #1;
      pen = 1'b1;
      @(posedge clk); #1;
      rstn = 1'b0;
      @(posedge clk); #1;
      chk("t6_pready", {63'd0, pready0}, 64'd0);
      rstn = 1'b1; psel0 = 1'b0; pen = 1'b0;
      xfer(1'b0, 1'b0, 12'h050, 32'h0, 4'h0, rd, err, acc);
      chk("t6_rd_acc",  64'(acc), 64'd3);
      chk("t6_rd_data", {32'd0, rd}, 64'd0);
      xfer(1'b0, 1'b0, 12'h040, 32'h0, 4'h0, rd, err, acc);
      chk("t6_cleared", {32'd0, rd}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
